// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding,
// default operand widths and the quotient reported on divide-by-zero.
package seq_divider_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough for any supported dividend width; sliced down at the use site.
  localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module seq_div_step
  import seq_divider_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0] r,
  input  logic                 q_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_next,
  output logic                 qbit
);

  logic [DIVISOR_W:0] trial_s;

  assign trial_s = {r, q_msb};

  // Restore step; the low bits of the difference are exact because the result is < divisor.
  always_comb begin
    r_next = trial_s[DIVISOR_W-1:0];
    qbit   = 1'b0;
    if (trial_s >= {1'b0, divisor}) begin
      r_next = trial_s[DIVISOR_W-1:0] - divisor;
      qbit   = 1'b1;
    end else begin
      r_next = trial_s[DIVISOR_W-1:0];
      qbit   = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// results registered and held until the next completion.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int                    CNT_W      = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVISOR_W-1:0]  ZERO_DIV   = {DIVISOR_W{1'b0}};
  localparam logic [DIVIDEND_W-1:0] DBZ_QUOT   = DBZ_QUOTIENT[DIVIDEND_W-1:0];

  state_t                  state_r, state_next_s;
  logic [CNT_W-1:0]        count_r;
  logic [DIVISOR_W-1:0]    r_r;
  logic [DIVIDEND_W-1:0]   q_r;
  logic [DIVISOR_W-1:0]    divisor_r;
  logic [DIVIDEND_W-1:0]   quotient_r;
  logic [DIVISOR_W-1:0]    remainder_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    dbz_r;

  logic                    accept_s;
  logic                    finish_s;
  logic [DIVISOR_W-1:0]    r_next_s;
  logic                    qbit_s;
  logic [DIVIDEND_W-1:0]   q_next_s;

  seq_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r       (r_r),
    .q_msb   (q_r[DIVIDEND_W-1]),
    .divisor (divisor_r),
    .r_next  (r_next_s),
    .qbit    (qbit_s)
  );

  assign q_next_s = {q_r[DIVIDEND_W-2:0], qbit_s};

  // Next-state decode; DONE accepts a new start exactly like IDLE.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = (divisor == ZERO_DIV) ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST_CNT) begin
          finish_s     = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, iteration datapath and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      count_r     <= {CNT_W{1'b0}};
      r_r         <= {DIVISOR_W{1'b0}};
      q_r         <= {DIVIDEND_W{1'b0}};
      divisor_r   <= {DIVISOR_W{1'b0}};
      quotient_r  <= {DIVIDEND_W{1'b0}};
      remainder_r <= {DIVISOR_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
      if (accept_s) begin
        divisor_r <= divisor;
        count_r   <= {CNT_W{1'b0}};
        r_r       <= {DIVISOR_W{1'b0}};
        q_r       <= dividend;
        if (divisor == ZERO_DIV) begin
          quotient_r  <= DBZ_QUOT;
          remainder_r <= dividend[DIVISOR_W-1:0];
          dbz_r       <= 1'b1;
        end
      end else if (state_r == RUN) begin
        r_r     <= r_next_s;
        q_r     <= q_next_s;
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (finish_s) begin
          quotient_r  <= q_next_s;
          remainder_r <= r_next_s;
          dbz_r       <= 1'b0;
        end
      end
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule
